// File: rtl/decode_issue_stage.sv
// Decode/issue stage: register file with writeback bypass, branch resolution, hazard detection and the ID/EX register.
// Optional stall counter output o_StallCnt is enabled with `define DECODE_ISSUE_STALL_CNT_EN.
module decode_issue_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSTR_WIDTH   = 32,
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_ValidD,
  input  logic [INSTR_WIDTH-1:0]   i_InstrD,
  input  logic [ADDRESS_WIDTH-1:0] i_PCPlus4D,
  output logic                     o_ReadyD,
  input  logic                     i_RegWriteW,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegW,
  input  logic [DATA_WIDTH-1:0]    i_ResultW,
  input  logic                     i_ForwardAD,
  input  logic                     i_ForwardBD,
  input  logic [DATA_WIDTH-1:0]    i_ALUOutM,
  input  logic                     i_ReadyE,
  input  logic                     i_FlushE,
  output logic                     o_ValidE,
  output logic [DATA_WIDTH-1:0]    o_SrcAE,
  output logic [DATA_WIDTH-1:0]    o_SrcBE,
  output logic [ADDRESS_WIDTH-1:0] o_SignImmE,
  output logic [RF_ADDR_WIDTH-1:0] o_RsE,
  output logic [RF_ADDR_WIDTH-1:0] o_RtE,
  output logic [RF_ADDR_WIDTH-1:0] o_RdE,
  output logic                     o_MemReadE,
  output logic [ADDRESS_WIDTH-1:0] o_PCBranchD,
  output logic                     o_BranchTakenD,
  output logic                     o_HazardD
`ifdef DECODE_ISSUE_STALL_CNT_EN
  ,
  output logic [31:0]              o_StallCnt
`endif
);

  localparam int RF_DEPTH = 1 << RF_ADDR_WIDTH;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;

  logic [DATA_WIDTH-1:0] regs [RF_DEPTH];

  logic [5:0]                      op;
  logic [RF_ADDR_WIDTH-1:0]        rs;
  logic [RF_ADDR_WIDTH-1:0]        rt;
  logic [RF_ADDR_WIDTH-1:0]        rd;
  logic [RF_ADDR_WIDTH-1:0]        dest;
  logic [DATA_WIDTH-1:0]           rd_a;
  logic [DATA_WIDTH-1:0]           rd_b;
  logic [DATA_WIDTH-1:0]           cmp_a;
  logic [DATA_WIDTH-1:0]           cmp_b;
  logic signed [ADDRESS_WIDTH-1:0] sign_imm;
  logic [ADDRESS_WIDTH-1:0]        imm_shift;
  logic                            is_branch;
  logic                            branch_cond;
  logic                            load_use;
  logic                            branch_haz;
  logic                            hazard;

  assign op   = i_InstrD[31:26];
  assign rs   = i_InstrD[21 +: RF_ADDR_WIDTH];
  assign rt   = i_InstrD[16 +: RF_ADDR_WIDTH];
  assign rd   = i_InstrD[11 +: RF_ADDR_WIDTH];
  assign dest = (op == OP_RTYPE) ? rd : rt;

  // Register reads see a same-cycle writeback; index 0 is hardwired to zero.
  always_comb begin
    rd_a = regs[rs];
    rd_b = regs[rt];
    if (rs == '0)
      rd_a = '0;
    else if (i_RegWriteW && (i_WriteRegW == rs))
      rd_a = i_ResultW;
    if (rt == '0)
      rd_b = '0;
    else if (i_RegWriteW && (i_WriteRegW == rt))
      rd_b = i_ResultW;
  end

  assign sign_imm    = {{(ADDRESS_WIDTH-16){i_InstrD[15]}}, i_InstrD[15:0]};
  assign imm_shift   = sign_imm <<< 2;
  assign o_PCBranchD = i_PCPlus4D + imm_shift;

  assign cmp_a       = i_ForwardAD ? i_ALUOutM : rd_a;
  assign cmp_b       = i_ForwardBD ? i_ALUOutM : rd_b;
  assign is_branch   = (op == OP_BEQ) || (op == OP_BNE);
  assign branch_cond = (op == OP_BEQ) ? (cmp_a == cmp_b) : (cmp_a != cmp_b);

  // o_RdE already holds the execute-stage destination, so branch hazards compare against it directly.
  assign load_use   = o_ValidE && o_MemReadE && (o_RtE != '0) && ((o_RtE == rs) || (o_RtE == rt));
  assign branch_haz = is_branch && o_ValidE && (o_RdE != '0) && ((o_RdE == rs) || (o_RdE == rt));
  assign hazard     = i_ValidD && (load_use || branch_haz);

  assign o_HazardD      = hazard;
  assign o_ReadyD       = i_ReadyE && !hazard;
  assign o_BranchTakenD = i_ValidD && is_branch && branch_cond && !hazard;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      for (int i = 0; i < RF_DEPTH; i++)
        regs[i] <= '0;
    end else if (i_RegWriteW && (i_WriteRegW != '0)) begin
      regs[i_WriteRegW] <= i_ResultW;
    end
  end

  // ---- ID/EX stage boundary ----
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      o_ValidE   <= 1'b0;
      o_MemReadE <= 1'b0;
      o_SrcAE    <= '0;
      o_SrcBE    <= '0;
      o_SignImmE <= '0;
      o_RsE      <= '0;
      o_RtE      <= '0;
      o_RdE      <= '0;
    end else if (i_FlushE) begin
      o_ValidE   <= 1'b0;
      o_MemReadE <= 1'b0;
    end else if (!i_ReadyE) begin
      o_ValidE   <= o_ValidE;
    end else if (hazard || !i_ValidD) begin
      o_ValidE   <= 1'b0;
      o_MemReadE <= 1'b0;
    end else begin
      o_ValidE   <= 1'b1;
      o_MemReadE <= (op == OP_LW);
      o_SrcAE    <= rd_a;
      o_SrcBE    <= rd_b;
      o_SignImmE <= sign_imm;
      o_RsE      <= rs;
      o_RtE      <= rt;
      o_RdE      <= dest;
    end
  end

`ifdef DECODE_ISSUE_STALL_CNT_EN
  always_ff @(posedge i_CLK) begin
    if (i_RST)
      o_StallCnt <= '0;
    else if (hazard && i_ReadyE)
      o_StallCnt <= o_StallCnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_decode_issue_stage.sv
// Randomized and directed bench for decode_issue_stage against a behavioural model of the decode/issue rules.
module tb_decode_issue_stage;

  logic        clk;
  logic        rst;
  logic        vd;
  logic [31:0] instr;
  logic [31:0] pc4;
  logic        ready_d;
  logic        regw;
  logic [4:0]  wr;
  logic [31:0] res;
  logic        fa;
  logic        fb;
  logic [31:0] alum;
  logic        ready_e;
  logic        flush;
  logic        valid_e;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] simm_e;
  logic [4:0]  rs_e;
  logic [4:0]  rt_e;
  logic [4:0]  rd_e;
  logic        memrd_e;
  logic [31:0] pc_branch;
  logic        taken;
  logic        hazard;
`ifdef DECODE_ISSUE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  decode_issue_stage dut (
    .i_CLK(clk), .i_RST(rst), .i_ValidD(vd), .i_InstrD(instr), .i_PCPlus4D(pc4),
    .o_ReadyD(ready_d), .i_RegWriteW(regw), .i_WriteRegW(wr), .i_ResultW(res),
    .i_ForwardAD(fa), .i_ForwardBD(fb), .i_ALUOutM(alum), .i_ReadyE(ready_e), .i_FlushE(flush),
    .o_ValidE(valid_e), .o_SrcAE(src_a), .o_SrcBE(src_b), .o_SignImmE(simm_e),
    .o_RsE(rs_e), .o_RtE(rt_e), .o_RdE(rd_e), .o_MemReadE(memrd_e),
    .o_PCBranchD(pc_branch), .o_BranchTakenD(taken), .o_HazardD(hazard)
`ifdef DECODE_ISSUE_STALL_CNT_EN
    , .o_StallCnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference state: architectural registers plus the instruction sitting in execute.
  logic [31:0] m_rf [32];
  logic        m_ve, m_mr;
  logic [31:0] m_sa, m_sb, m_si, m_cnt;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic        e_haz, e_rdy, e_tk;
  logic [31:0] e_pcb;
  logic [5:0]  ops [6] = '{6'h00, 6'h23, 6'h04, 6'h05, 6'h08, 6'h2b};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rdv(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (regw && wr == idx) return res;
    return m_rf[idx];
  endfunction

  function automatic logic [31:0] rtype(input int s, input int t, input int d);
    return {6'h00, 5'(s), 5'(t), 5'(d), 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int s, input int t, input logic [15:0] imm);
    return {op, 5'(s), 5'(t), imm};
  endfunction

  task automatic eval_comb();
    logic [5:0]  op;
    logic [4:0]  s, t;
    logic [31:0] ca, cb;
    logic        br, cond, lu, bh;
    op = instr[31:26];
    s  = instr[25:21];
    t  = instr[20:16];
    br = (op == 6'h04) || (op == 6'h05);
    ca = fa ? alum : rdv(s);
    cb = fb ? alum : rdv(t);
    cond  = (op == 6'h04) ? (ca == cb) : (ca != cb);
    lu    = m_ve && m_mr && m_rt != 0 && (m_rt == s || m_rt == t);
    bh    = br && m_ve && m_rd != 0 && (m_rd == s || m_rd == t);
    e_haz = vd && (lu || bh);
    e_rdy = ready_e && !e_haz;
    e_tk  = vd && br && cond && !e_haz;
    e_pcb = pc4 + ({{16{instr[15]}}, instr[15:0]} * 32'd4);
  endtask

  task automatic check_cycle();
    eval_comb();
    chk("valid_e", valid_e, m_ve);
    chk("hazard", hazard, e_haz);
    chk("ready_d", ready_d, e_rdy);
    chk("branch_taken", taken, e_tk);
    chk("pc_branch", pc_branch, e_pcb);
    if (m_ve) begin
      chk("src_a", src_a, m_sa);
      chk("src_b", src_b, m_sb);
      chk("sign_imm", simm_e, m_si);
      chk("rs_e", rs_e, m_rs);
      chk("rt_e", rt_e, m_rt);
      chk("rd_e", rd_e, m_rd);
      chk("mem_read", memrd_e, m_mr);
    end
`ifdef DECODE_ISSUE_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_cnt);
`endif
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_ve = 0; m_mr = 0; m_sa = 0; m_sb = 0; m_si = 0;
    m_rs = 0; m_rt = 0; m_rd = 0; m_cnt = 0;
  endtask

  task automatic model_update();
    logic [5:0] op;
    op = instr[31:26];
    if (rst) begin
      model_reset();
      return;
    end
    if (e_haz && ready_e) m_cnt = m_cnt + 1;
    if (flush) begin
      m_ve = 0; m_mr = 0;
    end else if (ready_e) begin
      if (e_haz || !vd) begin
        m_ve = 0; m_mr = 0;
      end else begin
        m_ve = 1;
        m_mr = (op == 6'h23);
        m_sa = rdv(instr[25:21]);
        m_sb = rdv(instr[20:16]);
        m_si = {{16{instr[15]}}, instr[15:0]};
        m_rs = instr[25:21];
        m_rt = instr[20:16];
        m_rd = (op == 6'h00) ? instr[15:11] : instr[20:16];
      end
    end
    if (regw && wr != 0) m_rf[wr] = res;
  endtask

  task automatic step();
    #2;
    check_cycle();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; vd = 0; instr = 0; pc4 = 0; regw = 0; wr = 0; res = 0;
    fa = 0; fb = 0; alum = 0; ready_e = 1; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 0;
    chk("reset_valid_e", valid_e, 1'b0);
    chk("reset_mem_read", memrd_e, 1'b0);
    chk("reset_src_a", src_a, 32'd0);
    chk("reset_rd_e", rd_e, 5'd0);

    // Same-cycle writeback bypass into decode read.
    vd = 1; instr = rtype(5, 0, 1); regw = 1; wr = 5; res = 32'h1234;
    step();
    regw = 0;
    chk("bypass_src_a", src_a, 32'h1234);
    chk("bypass_valid", valid_e, 1'b1);

    // Load-use: lw r2 then add r3,r2,r4.
    instr = itype(6'h23, 0, 2, 16'h0);
    step();
    instr = rtype(2, 4, 3);
    #1;
    chk("loaduse_hazard", hazard, 1'b1);
    chk("loaduse_ready", ready_d, 1'b0);
    step();
    chk("loaduse_bubble", valid_e, 1'b0);
    step();
    chk("loaduse_issue", valid_e, 1'b1);
    chk("loaduse_issue_rd", rd_e, 5'd3);

    // Branch resolution: beq/bne r1,r1 with offset 4.
    instr = itype(6'h04, 1, 1, 16'h0004); pc4 = 32'h100;
    #1;
    chk("beq_taken", taken, 1'b1);
    chk("beq_target", pc_branch, 32'h110);
    instr = itype(6'h05, 1, 1, 16'h0004);
    #1;
    chk("bne_taken", taken, 1'b0);
    step();

    // Backpressure hold then flush.
    instr = rtype(5, 0, 6);
    step();
    ready_e = 0; instr = rtype(1, 2, 7);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_ready_d", ready_d, 1'b0);
      step();
      chk("hold_valid", valid_e, 1'b1);
      chk("hold_src_a", src_a, 32'h1234);
      chk("hold_rd", rd_e, 5'd6);
    end
    ready_e = 1; flush = 1;
    step();
    flush = 0;
    chk("flush_valid", valid_e, 1'b0);

    // Writes to r0 are discarded.
    regw = 1; wr = 0; res = 32'hdead; instr = rtype(0, 0, 7);
    step();
    regw = 0;
    chk("r0_src_a", src_a, 32'd0);
    chk("r0_valid", valid_e, 1'b1);

    // Two load-use stalls, then reset while a stall is pending.
    rst = 1; step(); rst = 0;
    instr = itype(6'h23, 0, 2, 16'h0); step();
    instr = rtype(2, 4, 3); step(); step();
    instr = itype(6'h23, 0, 2, 16'h0); step();
    instr = rtype(2, 4, 3); step();
`ifdef DECODE_ISSUE_STALL_CNT_EN
    chk("stall_cnt_two", stall_cnt, 32'd2);
`endif
    instr = itype(6'h23, 0, 2, 16'h0); step();
    instr = rtype(2, 4, 3);
    #1;
    chk("pre_reset_hazard", hazard, 1'b1);
    rst = 1; step(); rst = 0;
    chk("post_reset_valid", valid_e, 1'b0);
    chk("post_reset_hazard", hazard, 1'b0);
`ifdef DECODE_ISSUE_STALL_CNT_EN
    chk("stall_cnt_cleared", stall_cnt, 32'd0);
`endif

    // Randomized traffic over a small register window so hazards are frequent.
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 99) == 0);
      vd      = ($urandom_range(0, 9) != 0);
      ready_e = ($urandom_range(0, 9) < 8);
      flush   = ($urandom_range(0, 19) == 0);
      regw    = $urandom_range(0, 1);
      wr      = 5'($urandom_range(0, 7));
      res     = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      fa      = ($urandom_range(0, 3) == 0);
      fb      = ($urandom_range(0, 3) == 0);
      alum    = ($urandom_range(0, 1) == 0) ? res : $urandom;
      pc4     = $urandom & 32'hffff_fffc;
      if (ops[$urandom_range(0, 5)] == 6'h00)
        instr = rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      else
        instr = itype(ops[$urandom_range(1, 5)], $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
